// File: rtl/jk_reg_bank.sv
// Vector of WIDTH JK flip-flops that can also act as a modulo up/down counter
// or a parallel-load register, with registered wrap (tc) and change pulses.
module jk_reg_bank #(
    parameter int unsigned         WIDTH     = 8,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0,
    parameter longint unsigned     MOD       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             tc,
    output logic             changed
);

    localparam int unsigned     W1        = WIDTH + 1;
    localparam longint unsigned MOD_EFF_L = (MOD == 0) ? (64'd1 << WIDTH) : MOD;
    // Modulus and its top value kept one bit wider so 2**WIDTH is representable.
    localparam logic [W1-1:0]    MOD_EFF   = W1'(MOD_EFF_L);
    localparam logic [W1-1:0]    MOD_MAX   = MOD_EFF - W1'(1);
    localparam logic [WIDTH-1:0] Q_MAX     = WIDTH'(MOD_MAX);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             changed_q, changed_d;
    logic [W1-1:0]    q_ext;
    logic [W1-1:0]    d_ext;

    assign q_ext = {1'b0, q_q};
    assign d_ext = {1'b0, d};

    // Next-state selection; hold and clear pulses unless enabled.
    always_comb begin
        q_d       = q_q;
        tc_d      = 1'b0;
        changed_d = 1'b0;
        if (en) begin
            case (mode)
                MODE_JK: begin
                    q_d = (J & ~q_q) | (~K & q_q);
                end
                MODE_UP: begin
                    if (q_ext >= MOD_MAX) begin
                        q_d  = '0;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (q_q == '0) begin
                        q_d  = Q_MAX;
                        tc_d = 1'b1;
                    end else if (q_ext >= MOD_EFF) begin
                        q_d = Q_MAX;
                    end else begin
                        q_d = q_q - WIDTH'(1);
                    end
                end
                MODE_LOAD: begin
                    q_d = (d_ext >= MOD_EFF) ? Q_MAX : d;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
            changed_d = (q_d != q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q       <= RESET_VAL;
            tc_q      <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            tc_q      <= tc_d;
            changed_q <= changed_d;
        end
    end

    assign Q       = q_q;
    assign Qn      = ~q_q;
    assign tc      = tc_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Drives three jk_reg_bank configurations with shared directed and random
// stimulus and compares every output against an arithmetic reference model.
module tb_jk_reg_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] j_in = '0, k_in = '0, d_in = '0;

    logic [3:0] q_a, qn_a, q_b, qn_b;
    logic [7:0] q_c, qn_c;
    logic       tc_a, ch_a, tc_b, ch_b, tc_c, ch_c;

    int n_tests = 0;
    int n_fail  = 0;

    // a: 4-bit full range, b: 4-bit modulo 10, c: 8-bit full range
    longint unsigned m_w[3]  = '{4, 4, 8};
    longint unsigned m_m[3]  = '{16, 10, 256};
    longint unsigned m_rv[3] = '{10, 3, 0};
    longint unsigned mq[3];
    bit              mtc[3];
    bit              mch[3];

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .MOD(0)) u_a (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .J(j_in[3:0]), .K(k_in[3:0]), .d(d_in[3:0]),
        .Q(q_a), .Qn(qn_a), .tc(tc_a), .changed(ch_a));

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'd3), .MOD(10)) u_b (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .J(j_in[3:0]), .K(k_in[3:0]), .d(d_in[3:0]),
        .Q(q_b), .Qn(qn_b), .tc(tc_b), .changed(ch_b));

    jk_reg_bank #(.WIDTH(8), .RESET_VAL(8'h00), .MOD(0)) u_c (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .J(j_in), .K(k_in), .d(d_in),
        .Q(q_c), .Qn(qn_c), .tc(tc_c), .changed(ch_c));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one clock edge applied to instance n using the spec rules.
    task automatic model_edge(input int n);
        longint unsigned w, m, mask, q, nq, jj, kk, dd;
        bit t;
        w    = m_w[n];
        m    = m_m[n];
        mask = (64'd1 << w) - 1;
        q    = mq[n];
        jj   = longint'(j_in) & mask;
        kk   = longint'(k_in) & mask;
        dd   = longint'(d_in) & mask;
        nq   = q;
        t    = 1'b0;
        if (reset) begin
            mq[n] = m_rv[n]; mtc[n] = 1'b0; mch[n] = 1'b0;
            return;
        end
        if (!en) begin
            mtc[n] = 1'b0; mch[n] = 1'b0;
            return;
        end
        case (mode)
            2'b00: begin
                nq = 0;
                for (int i = 0; i < int'(w); i++) begin
                    bit jb, kb, qb, nb;
                    jb = jj[i]; kb = kk[i]; qb = q[i];
                    if (!jb && !kb)     nb = qb;
                    else if (!jb && kb) nb = 1'b0;
                    else if (jb && !kb) nb = 1'b1;
                    else                nb = !qb;
                    if (nb) nq = nq | (64'd1 << i);
                end
            end
            2'b01: begin
                if (q + 1 >= m) begin nq = 0; t = 1'b1; end
                else nq = q + 1;
            end
            2'b10: begin
                if (q == 0) begin nq = m - 1; t = 1'b1; end
                else if (q >= m) nq = m - 1;
                else nq = q - 1;
            end
            default: nq = (dd >= m) ? m - 1 : dd;
        endcase
        mch[n] = (nq != q);
        mtc[n] = t;
        mq[n]  = nq;
    endtask

    task automatic check_all();
        check("a_q",  64'(q_a),  mq[0]);
        check("a_qn", 64'(qn_a), ~mq[0] & 64'hF);
        check("a_tc", 64'(tc_a), 64'(mtc[0]));
        check("a_ch", 64'(ch_a), 64'(mch[0]));
        check("b_q",  64'(q_b),  mq[1]);
        check("b_qn", 64'(qn_b), ~mq[1] & 64'hF);
        check("b_tc", 64'(tc_b), 64'(mtc[1]));
        check("b_ch", 64'(ch_b), 64'(mch[1]));
        check("c_q",  64'(q_c),  mq[2]);
        check("c_qn", 64'(qn_c), ~mq[2] & 64'hFF);
        check("c_tc", 64'(tc_c), 64'(mtc[2]));
        check("c_ch", 64'(ch_c), 64'(mch[2]));
    endtask

    // One clock edge: advance the model with the sampled inputs, then compare.
    task automatic step();
        @(posedge clk);
        for (int n = 0; n < 3; n++) model_edge(n);
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] md,
                         input logic [7:0] j, input logic [7:0] k, input logic [7:0] dv);
        reset = r; en = e; mode = md; j_in = j; k_in = k; d_in = dv;
    endtask

    initial begin
        for (int n = 0; n < 3; n++) begin mq[n] = 0; mtc[n] = 0; mch[n] = 0; end

        // Reset, then JK truth table on the 4-bit register
        drive(1, 0, 2'b00, 8'h00, 8'h00, 8'h00);
        step();
        check("rst_q", 64'(q_a), 64'hA);
        check("rst_qn", 64'(qn_a), 64'h5);
        drive(0, 1, 2'b00, 8'h03, 8'h05, 8'h00);
        step();
        check("jk_q", 64'(q_a), 64'hB);
        check("jk_changed", 64'(ch_a), 64'd1);
        check("jk_tc", 64'(tc_a), 64'd0);

        // Modulo-10 up count from 0 over the wrap
        drive(0, 1, 2'b11, 8'h00, 8'h00, 8'h00);
        step();
        drive(0, 1, 2'b01, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step();
            check("up_seq", 64'(q_b), 64'((i + 1) % 10));
            check("up_tc", 64'(tc_b), 64'(i == 9));
        end

        // Out-of-range recovery on down count, then down wrap from 0
        drive(0, 1, 2'b00, 8'hFF, 8'h00, 8'h00);
        step();
        check("set_f", 64'(q_b), 64'hF);
        drive(0, 1, 2'b10, 8'h00, 8'h00, 8'h00);
        step();
        check("down_oor", 64'(q_b), 64'd9);
        check("down_oor_tc", 64'(tc_b), 64'd0);
        step();
        check("down_8", 64'(q_b), 64'd8);
        drive(0, 1, 2'b11, 8'h00, 8'h00, 8'h00);
        step();
        drive(0, 1, 2'b10, 8'h00, 8'h00, 8'h00);
        step();
        check("down_wrap", 64'(q_b), 64'd9);
        check("down_wrap_tc", 64'(tc_b), 64'd1);

        // Load clamp, then enable low holds everything
        drive(0, 1, 2'b11, 8'h00, 8'h00, 8'd12);
        step();
        check("load_clamp", 64'(q_b), 64'd9);
        drive(0, 0, 2'b01, 8'h00, 8'h00, 8'd12);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_q", 64'(q_b), 64'd9);
            check("hold_tc", 64'(tc_b), 64'd0);
            check("hold_ch", 64'(ch_b), 64'd0);
        end

        // Full-range 8-bit wrap in both directions
        drive(0, 1, 2'b11, 8'h00, 8'h00, 8'hFF);
        step();
        drive(0, 1, 2'b01, 8'h00, 8'h00, 8'h00);
        step();
        check("full_up", 64'(q_c), 64'h00);
        check("full_up_tc", 64'(tc_c), 64'd1);
        drive(0, 1, 2'b10, 8'h00, 8'h00, 8'h00);
        step();
        check("full_down", 64'(q_c), 64'hFF);
        check("full_down_tc", 64'(tc_c), 64'd1);

        // Reset on the edge where the modulo-10 counter would wrap
        drive(0, 1, 2'b11, 8'h00, 8'h00, 8'd9);
        step();
        drive(1, 1, 2'b01, 8'h00, 8'h00, 8'h00);
        step();
        check("mid_rst_q", 64'(q_b), 64'd3);
        check("mid_rst_tc", 64'(tc_b), 64'd0);
        check("mid_rst_ch", 64'(ch_b), 64'd0);
        drive(0, 1, 2'b01, 8'h00, 8'h00, 8'h00);
        step();
        check("resume", 64'(q_b), 64'd4);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                  2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
